// File: rtl/timekeeper_pkg.sv
// Shared encodings and limits for the runtime timekeeper.
// Used by runtime_timekeeper and runtime_channel.
package timekeeper_pkg;

  typedef enum logic [1:0] {
    MODE_RUN        = 2'b00,
    MODE_SET_TOD    = 2'b01,
    MODE_SET_REMIND = 2'b10,
    MODE_RSVD       = 2'b11
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/runtime_channel.sv
// One run-time accumulator: prescaler, h:m:s, saturation, clear.
// Threshold and remind exist only with RUNTIME_REMIND_EN defined.
module runtime_channel
  import timekeeper_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int HOUR_W       = 6,
  parameter int REMIND_H_DEF = 10,
  parameter int REMIND_M_DEF = 0
) (
  input  logic              clk_100Hz,
  input  logic              reset,
  input  logic              power_on,
  input  logic              run,
  input  logic              clear,
  input  logic              thr_load,
  input  logic [5:0]        thr_hour,
  input  logic [5:0]        thr_min,
  output logic [HOUR_W-1:0] hours,
  output logic [5:0]        minutes,
  output logic              remind
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [HOUR_W-1:0] H_SAT = '1;

  logic [PS_W-1:0]   ps_q, ps_d;
  logic [5:0]        sec_q, sec_d;
  logic [5:0]        min_q, min_d;
  logic [HOUR_W-1:0] hr_q, hr_d;
  logic              kill;
  logic              sat;

  assign kill = clear | ~power_on;
  assign sat  = (hr_q == H_SAT) && (min_q == MIN_MAX) &&
                (sec_q == SEC_MAX);

  // count while running; clear wins; stop once saturated
  always_comb begin
    ps_d  = ps_q;
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (kill) begin
      ps_d  = '0;
      sec_d = '0;
      min_d = '0;
      hr_d  = '0;
    end else if (run && !sat) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d = '0;
            hr_d  = hr_q + 1'b1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      ps_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      ps_q  <= ps_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  assign hours   = hr_q;
  assign minutes = min_q;

`ifdef RUNTIME_REMIND_EN
  localparam int CW = (HOUR_W > 6) ? HOUR_W : 6;

  logic [5:0] thr_h_q, thr_h_d;
  logic [5:0] thr_m_q, thr_m_d;
  logic       rem_q, rem_d;
  logic       hit;

  assign hit = ((thr_h_q != 6'd0) || (thr_m_q != 6'd0)) &&
               ({CW'(hr_q), min_q} >= {CW'(thr_h_q), thr_m_q});

  // threshold load and sticky compare flag
  always_comb begin
    thr_h_d = thr_h_q;
    thr_m_d = thr_m_q;
    if (thr_load) begin
      thr_h_d = thr_hour;
      thr_m_d = thr_min;
    end
    rem_d = kill ? 1'b0 : (rem_q | hit);
  end

  // threshold and remind registers
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      thr_h_q <= 6'(REMIND_H_DEF);
      thr_m_q <= 6'(REMIND_M_DEF);
      rem_q   <= 1'b0;
    end else begin
      thr_h_q <= thr_h_d;
      thr_m_q <= thr_m_d;
      rem_q   <= rem_d;
    end
  end

  assign remind = rem_q;
`else
  logic unused_thr;
  assign unused_thr = ^{thr_load, thr_hour, thr_min,
                        6'(REMIND_H_DEF), 6'(REMIND_M_DEF)};
  assign remind = 1'b0;
`endif

endmodule

// File: rtl/runtime_timekeeper.sv
// Time of day plus N_CH run-time accumulators on the 100 Hz tick.
// Define RUNTIME_REMIND_EN for per-channel thresholds and remind.
module runtime_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int N_CH         = 2,
  parameter int HOUR_W       = 6,
  parameter int REMIND_H_DEF = 10,
  parameter int REMIND_M_DEF = 0
) (
  input  logic                     clk_100Hz,
  input  logic                     reset,
  input  logic                     power_on,
  input  logic [1:0]               set_mode,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] set_ch,
  input  logic [5:0]               set_hour,
  input  logic [5:0]               set_min,
  input  logic [N_CH-1:0]          ch_run,
  input  logic [N_CH-1:0]          ch_clear,
  output logic [4:0]               tod_hour,
  output logic [5:0]               tod_min,
  output logic [5:0]               tod_sec,
  output logic                     sec_pulse,
  output logic [N_CH*HOUR_W-1:0]   ch_hours,
  output logic [N_CH*6-1:0]        ch_minutes,
  output logic [N_CH-1:0]          remind
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hr_q, hr_d;
  logic            pulse_q, pulse_d;
  logic            tod_ok;
  logic            thr_ok;

  assign tod_ok = (set_hour <= 6'(HOUR_MAX)) && (set_min <= MIN_MAX);
  assign thr_ok = power_on && (set_mode == MODE_SET_REMIND) &&
                  (set_min <= MIN_MAX);

  // time-of-day: clear, load/freeze, or count with carries
  always_comb begin
    ps_d    = ps_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pulse_d = 1'b0;
    if (!power_on) begin
      ps_d  = '0;
      sec_d = '0;
      min_d = '0;
      hr_d  = '0;
    end else if (set_mode == MODE_SET_TOD) begin
      if (tod_ok) begin
        ps_d  = '0;
        sec_d = '0;
        min_d = set_min;
        hr_d  = set_hour[4:0];
      end
    end else if (ps_q == PS_LAST) begin
      ps_d    = '0;
      pulse_d = 1'b1;
      if (sec_q == SEC_MAX) begin
        sec_d = '0;
        if (min_q == MIN_MAX) begin
          min_d = '0;
          hr_d  = (hr_q == HOUR_MAX) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      ps_d = ps_q + 1'b1;
    end
  end

  // time-of-day registers
  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      ps_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pulse_q <= pulse_d;
    end
  end

  assign tod_hour  = hr_q;
  assign tod_min   = min_q;
  assign tod_sec   = sec_q;
  assign sec_pulse = pulse_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    runtime_channel #(
      .TICK_DIV     (TICK_DIV),
      .HOUR_W       (HOUR_W),
      .REMIND_H_DEF (REMIND_H_DEF),
      .REMIND_M_DEF (REMIND_M_DEF)
    ) u_ch (
      .clk_100Hz (clk_100Hz),
      .reset     (reset),
      .power_on  (power_on),
      .run       (ch_run[i]),
      .clear     (ch_clear[i]),
      .thr_load  (thr_ok && (set_ch == CH_W'(i))),
      .thr_hour  (set_hour),
      .thr_min   (set_min),
      .hours     (ch_hours[i*HOUR_W +: HOUR_W]),
      .minutes   (ch_minutes[i*6 +: 6]),
      .remind    (remind[i])
    );
  end

endmodule

// File: doc/runtime_timekeeper.md
# runtime_timekeeper

Parametrised time-of-day clock plus N independent run-time accumulators with per-channel reminder thresholds, clocked from the 100 Hz system tick. Next generation of the appliance timekeeping block: proper same-cycle carries, 24 h wrap, per-channel pause/clear, configurable prescaler and channel count. Feeds the display mux (time of day, run hours) and the control FSM (remind flags).

## Interface
- TICK_DIV, 100: clk_100Hz cycles per second, ≥2.
- N_CH, 2: number of run-time channels, 1..8.
- HOUR_W, 6: channel hour counter width.
- REMIND_H_DEF, 10: reset threshold hours, all channels.
- REMIND_M_DEF, 0: reset threshold minutes, all channels.

Ports:
- clk_100Hz  in  1  system tick clock.
- reset  in  1  asynchronous, active-high.
- power_on  in  1  low = synchronous clear of all counters and remind; thresholds kept.
- set_mode  in  2  00 run, 01 load time of day, 10 load threshold, 11 treated as 00.
- set_ch  in  max(1,$clog2(N_CH))  threshold target channel.
- set_hour  in  6  load value, hours.
- set_min  in  6  load value, minutes.
- ch_run  in  N_CH  channel accumulates while high.
- ch_clear  in  N_CH  channel clear request, level.
- tod_hour  out  5  0..23.
- tod_min  out  6  0..59.
- tod_sec  out  6  0..59.
- sec_pulse  out  1  one-cycle strobe on each tod second increment.
- ch_hours  out  N_CH*HOUR_W  packed, channel 0 in LSBs.
- ch_minutes  out  N_CH*6  packed, 0..59.
- remind  out  N_CH  registered threshold flags.

## Operation
- Reset: all outputs 0; prescalers 0; thresholds = REMIND_H_DEF:REMIND_M_DEF.
- Time of day: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0, sec increments, sec_pulse=1 that cycle. 59 s→0 with min+1 in the same edge; 59 min→0 with hour+1; 23:59:59→00:00:00. No counter ever shows 60 or 24.
- set_mode 01: tod loads set_hour:set_min, sec=0, prescaler=0, sec_pulse=0. Load ignored (tod holds) if set_hour>23 or set_min>59. Tod frozen while held in 01.
- set_mode 10: threshold[set_ch] loads set_hour:set_min; ignored if set_min>59 or set_ch≥N_CH. Tod and channels keep running.
- Channel i: own prescaler and hidden seconds; advances only when ch_run[i]=1, paused values retained. Same carry rules as tod; hours saturate at 2^HOUR_W-1 with minutes/seconds held at 59.
- ch_clear[i] has priority over ch_run[i]: prescaler, sec, min, hours, remind[i] → 0 next edge.
- remind[i] = registered (hours:minutes ≥ threshold), sticky until ch_clear[i] or power_on low. Threshold 00:00 disables channel remind.
- power_on low: tod, all channels, prescalers, remind cleared every cycle; set_mode ignored.

## Timing
- All state on posedge clk_100Hz; reset async assert, sync-safe release.
- Counter outputs registered; carries settle in the edge that generates them.
- remind[i] rises one cycle after the count edge reaching threshold.
- Threshold load effective for the comparison on the following edge.
- Load and clear take one edge; no handshake, inputs sampled level.

## Configuration
- RUNTIME_REMIND_EN defined: thresholds, comparators and remind as above.
- Undefined: no threshold registers; set_mode 10 is a no-op; remind tied to 0.

## Structure
- Package timekeeper_pkg: set_mode encodings (MODE_RUN, MODE_SET_TOD, MODE_SET_REMIND), SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- Sub-module runtime_channel: one accumulator (prescaler, sec/min/hours, saturation, clear, threshold compare), generated N_CH times; tod logic stays in top.

## Test plan
- TICK_DIV=4, set 23:59, run 4 cycles → tod 23:59:01; run to 23:59:59 then 4 cycles → 00:00:00, sec_pulse single-cycle each second.
- set_mode 01 with set_hour=24 → tod unchanged; set_hour=12,set_min=30 → 12:30:00 next edge, prescaler restarts.
- Threshold ch1=00:02, ch_run=2'b10 for 120 s → remind=2'b10 one cycle after ch1 reads 00:02; ch0 stays 0:00.
- ch_run toggled low mid-second then high → count resumes without loss; ch_clear with ch_run high → all zero, remind cleared.
- HOUR_W=2, run to 03:59 → holds 03:59; power_on low one cycle → all counters 0, thresholds unchanged.
- Async reset mid-count → outputs 0 immediately; thresholds back to 10:00.
